// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions.
//
// Holds the init/ready state encoding used by the PHT sweep FSM and the
// default parameter values for the gshare pattern history table.
package bp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_t;

  localparam int DEF_INDEX_W  = 8;
  localparam int DEF_CTR_W    = 2;
  localparam int DEF_HIST_W   = 8;
  localparam int DEF_INIT_VAL = 1;  // weakly not-taken

endpackage : bp_pkg

// File: rtl/sat_counter.sv
// Saturating up/down counter update (combinational).
//
// Ports:
//   value      - current counter value
//   taken      - resolved branch direction (1 = count up, 0 = count down)
//   next_value - updated counter, clamped at 0 and at 2**CTR_W-1
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] value,
  input  logic             taken,
  output logic [CTR_W-1:0] next_value
);

  always_comb begin
    // NOTE: default first so every path assigns next_value and no latch is inferred.
    next_value = value;
    if (taken) begin
      if (value != '1) next_value = value + 1'b1;
    end else begin
      if (value != '0) next_value = value - 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/gshare_pht.sv
// Gshare pattern history table with non-speculative global history.
//
// A lookup hashes lookup_pc with the global history register and returns the
// saturating counter one cycle later. Resolved branches train the addressed
// counter and shift their direction into the history. After reset or
// pht_clear, an init sweep writes INIT_VAL to every entry, one per cycle;
// lookups and updates are dropped while it runs.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   pht_clear             - re-initialise the table and clear the history
//   lookup_valid/_pc      - lookup request and its PC index bits
//   pred_valid/_taken/    - registered prediction: valid, counter MSB,
//   pred_ctr/_index         counter value, hashed index for later update
//   upd_valid/_index/     - resolved-branch training request
//   upd_taken
//   init_busy             - init sweep in progress
//   ghr_out               - current global history
module gshare_pht
  import bp_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int HIST_W   = DEF_HIST_W,
  parameter int INIT_VAL = DEF_INIT_VAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pht_clear,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [CTR_W-1:0]   pred_ctr,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               init_busy,
  output logic [HIST_W-1:0]  ghr_out
);

  localparam int ENTRIES = 2 ** INDEX_W;

  init_state_t        state, state_next;
  logic [INDEX_W-1:0] ptr, ptr_next;
  logic [HIST_W-1:0]  ghr;

  logic [CTR_W-1:0]   pht_mem [ENTRIES];

  logic               upd_accept;
  logic               lookup_accept;
  logic [CTR_W-1:0]   upd_next;
  logic [INDEX_W-1:0] lookup_index;
  logic [CTR_W-1:0]   lookup_ctr;

  logic               mem_we;
  logic [INDEX_W-1:0] mem_waddr;
  logic [CTR_W-1:0]   mem_wdata;

  // pht_clear outranks both request types in the same cycle.
  assign upd_accept    = upd_valid    && (state == READY) && !pht_clear;
  assign lookup_accept = lookup_valid && (state == READY) && !pht_clear;

  // Hash uses the pre-shift history, including when an update lands this cycle.
  assign lookup_index = lookup_pc ^ INDEX_W'(ghr);

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .value      (pht_mem[upd_index]),
    .taken      (upd_taken),
    .next_value (upd_next)
  );

  // Write-to-read bypass: a same-cycle update to the looked-up entry is
  // visible in the prediction.
  assign lookup_ctr = (upd_accept && (upd_index == lookup_index))
                    ? upd_next : pht_mem[lookup_index];

  // Init sweep FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all registered state avoid ordering races between blocks.
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (pht_clear) begin
      state_next = INIT;
      ptr_next   = '0;
    end else if (state == INIT) begin
      ptr_next = ptr + 1'b1;
      if (ptr == '1) state_next = READY;
    end
  end

  assign init_busy = (state == INIT);

  // Single write port: the sweep owns it during INIT, training during READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = CTR_W'(INIT_VAL);
    if (!pht_clear) begin
      if (state == INIT) begin
        mem_we = 1'b1;
      end else if (upd_valid) begin
        mem_we    = 1'b1;
        mem_waddr = upd_index;
        mem_wdata = upd_next;
      end
    end
  end

  // NOTE: the table has no reset; its contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (mem_we) pht_mem[mem_waddr] <= mem_wdata;
  end

  // Global history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (pht_clear) begin
      ghr <= '0;
    end else if (upd_accept) begin
      ghr <= (ghr << 1) | HIST_W'(upd_taken);
    end
  end

  assign ghr_out = ghr;

  // Prediction registers; payload holds between accepted lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= '0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_accept;
      if (lookup_accept) begin
        pred_taken <= lookup_ctr[CTR_W-1];
        pred_ctr   <= lookup_ctr;
        pred_index <= lookup_index;
      end
    end
  end

endmodule : gshare_pht

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht at default parameters.
module tb_gshare_pht;

  logic       clk;
  logic       rst_n;
  logic       pht_clear;
  logic       lookup_valid;
  logic [7:0] lookup_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [1:0] pred_ctr;
  logic [7:0] pred_index;
  logic       upd_valid;
  logic [7:0] upd_index;
  logic       upd_taken;
  logic       init_busy;
  logic [7:0] ghr_out;

  gshare_pht dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pht_clear    (pht_clear),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ctr     (pred_ctr),
    .pred_index   (pred_index),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_taken    (upd_taken),
    .init_busy    (init_busy),
    .ghr_out      (ghr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    bit         taken;
    logic [1:0] ctr;
    logic [7:0] idx;
  } exp_t;

  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  bit         m_ready;
  logic [7:0] m_ptr;
  logic [7:0] m_ghr;
  logic [1:0] m_tbl [256];

  function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
    if (t) return (v == 2'd3) ? 2'd3 : v + 2'd1;
    else   return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_ptr   = 8'd0;
    m_ghr   = 8'd0;
  endtask

  // Called away from the clock edge: drive one cycle of inputs, push the
  // expected prediction, advance one edge, then pop and compare.
  task automatic step(input bit lv, input logic [7:0] pc, input bit uv,
                      input logic [7:0] ui, input bit ut, input bit clr);
    exp_t       e;
    logic [7:0] idx;
    bit         upd_ok;
    lookup_valid = lv;
    lookup_pc    = pc;
    upd_valid    = uv;
    upd_index    = ui;
    upd_taken    = ut;
    pht_clear    = clr;
    idx     = pc ^ m_ghr;
    upd_ok  = uv && m_ready && !clr;
    e.valid = lv && m_ready && !clr;
    e.ctr   = m_tbl[idx];
    if (upd_ok && ui == idx) e.ctr = sat(m_tbl[ui], ut);
    e.taken = e.ctr[1];
    e.idx   = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (!m_ready) begin
      m_tbl[m_ptr] = 2'd1;
      if (m_ptr == 8'd255) m_ready = 1'b1;
      m_ptr = m_ptr + 8'd1;
    end else if (uv) begin
      m_tbl[ui] = sat(m_tbl[ui], ut);
      m_ghr     = {m_ghr[6:0], ut};
    end
    e = sb.pop_front();
    check("pred_valid", pred_valid, e.valid);
    if (e.valid) begin
      check("pred_ctr", pred_ctr, e.ctr);
      check("pred_taken", pred_taken, e.taken);
      check("pred_index", pred_index, e.idx);
    end
    check("init_busy", init_busy, !m_ready);
    check("ghr_out", ghr_out, m_ghr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pred_valid"}, pred_valid, 0);
    check({tag, "_pred_taken"}, pred_taken, 0);
    check({tag, "_pred_ctr"},   pred_ctr,   0);
    check({tag, "_pred_index"}, pred_index, 0);
    check({tag, "_init_busy"},  init_busy,  1);
    check({tag, "_ghr"},        ghr_out,    0);
  endtask

  initial begin
    logic [7:0] ui;
    logic [7:0] pc;
    rst_n        = 1'b0;
    pht_clear    = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = 8'h00;
    upd_valid    = 1'b0;
    upd_index    = 8'h00;
    upd_taken    = 1'b0;
    model_reset();

    // Reset state and first sweep: busy for exactly 256 cycles.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(256);

    // Fresh entry reads weakly not-taken.
    step(1, 8'h00, 0, 8'h00, 0, 0);

    // Four taken updates to 0x05 saturate it and fill the history.
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 8'h05, 1, 0);
    check("ghr_0f", ghr_out, 8'h0F);
    step(1, 8'h0A, 0, 8'h00, 0, 0);
    check("sat_hi_index", pred_index, 8'h05);
    check("sat_hi_ctr", pred_ctr, 2'd3);

    // Counter floors at zero.
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 8'h10, 0, 0);
    step(1, 8'h10 ^ m_ghr, 0, 8'h00, 0, 0);
    check("sat_lo_ctr3", pred_ctr, 2'd0);
    step(0, 8'h00, 1, 8'h10, 0, 0);
    step(1, 8'h10 ^ m_ghr, 0, 8'h00, 0, 0);
    check("sat_lo_ctr4", pred_ctr, 2'd0);

    // Bring history to zero, then same-cycle lookup/update bypass.
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 8'h30, 0, 0);
    check("ghr_zero", ghr_out, 8'h00);
    step(1, 8'h20, 1, 8'h20, 1, 0);
    check("bypass_ctr", pred_ctr, 2'd2);
    check("bypass_ghr", ghr_out, 8'h01);

    // Mixed traffic concentrated on a few entries to exercise collisions.
    for (int i = 0; i < 60; i++) begin
      ui = 8'h40 + 8'($urandom_range(0, 3));
      pc = ($urandom_range(0, 1) == 1) ? (ui ^ m_ghr) : 8'($urandom_range(0, 255));
      step(bit'($urandom_range(0, 1)), pc, bit'($urandom_range(0, 1)), ui,
           bit'($urandom_range(0, 1)), 0);
    end

    // Clear wins over a simultaneous update and lookup.
    step(1, 8'h33, 1, 8'h05, 1, 1);
    check("clear_ghr", ghr_out, 8'h00);
    idle(256);
    for (int i = 0; i < 256; i++) step(1, 8'(i), 0, 8'h00, 0, 0);

    // Async reset during a sweep restarts it in full.
    step(0, 8'h00, 0, 8'h00, 0, 1);
    idle(100);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsweep_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(256);
    step(1, 8'h07, 0, 8'h00, 0, 0);
    check("post_reset_ctr", pred_ctr, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_gshare_pht

// File: doc/gshare_pht.md
GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 The module SHALL have parameter INDEX_W, default 8, giving the table index width (2**INDEX_W entries).
REQ-002 The module SHALL have parameter CTR_W, default 2, giving the saturating-counter width (CTR_W >= 2).
REQ-003 The module SHALL have parameter HIST_W, default 8, giving the global-history width (1 <= HIST_W <= INDEX_W).
REQ-004 The module SHALL have parameter INIT_VAL, default 1, giving the post-init counter value (weakly not-taken).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port pht_clear, input, 1 bit: synchronous request to re-initialise the table.
REQ-008 The module SHALL have port lookup_valid, input, 1 bit: a lookup request this cycle.
REQ-009 The module SHALL have port lookup_pc, input, INDEX_W bits: PC index bits of the lookup.
REQ-010 The module SHALL have port pred_valid, output, 1 bit: prediction outputs are valid.
REQ-011 The module SHALL have port pred_taken, output, 1 bit: the counter MSB.
REQ-012 The module SHALL have port pred_ctr, output, CTR_W bits: the counter value.
REQ-013 The module SHALL have port pred_index, output, INDEX_W bits: the hashed index, carried down the pipeline for update.
REQ-014 The module SHALL have port upd_valid, input, 1 bit: a resolved-branch update this cycle.
REQ-015 The module SHALL have port upd_index, input, INDEX_W bits: the entry to train.
REQ-016 The module SHALL have port upd_taken, input, 1 bit: the resolved direction.
REQ-017 The module SHALL have port init_busy, output, 1 bit: an initialisation sweep is in progress.
REQ-018 The module SHALL have port ghr_out, output, HIST_W bits: the current global history.

Function
REQ-019 The lookup index SHALL be lookup_pc XOR the zero-extended GHR, sampled in the cycle lookup_valid is high.
REQ-020 pred_valid, pred_taken, pred_ctr and pred_index SHALL be registered, appearing one cycle after lookup_valid.
REQ-021 pred_valid SHALL be low in any cycle following a cycle with no accepted lookup.
REQ-022 On upd_valid, entry[upd_index] SHALL become old+1 when upd_taken=1 and old-1 when upd_taken=0, saturating at 2**CTR_W-1 and at 0, written at the clock edge.
REQ-023 On upd_valid, the GHR SHALL shift left, inserting upd_taken at the LSB (non-speculative history).
REQ-024 When the lookup index equals upd_index in the same cycle, the prediction SHALL return the post-update counter value (write-to-read bypass).
REQ-025 The index hash in the bypass case SHALL use the pre-shift GHR.
REQ-026 The init FSM SHALL have two states: INIT (sweep pointer writes INIT_VAL to one entry per cycle, 0 up to 2**INDEX_W-1) and READY.
REQ-027 The FSM SHALL move INIT->READY in the cycle after the last entry is written.
REQ-028 A full sweep SHALL take exactly 2**INDEX_W cycles.
REQ-029 init_busy SHALL equal (state==INIT).
REQ-030 While in INIT, lookups SHALL be dropped (pred_valid=0) and updates SHALL be ignored, for both table and GHR.
REQ-031 pht_clear in READY SHALL enter INIT, reset the pointer to 0 and clear the GHR.
REQ-032 pht_clear in INIT SHALL restart the sweep from 0.
REQ-033 pht_clear SHALL take priority over a simultaneous update or lookup, which are dropped.

Reset
REQ-034 rst_n low SHALL asynchronously force state=INIT, pointer=0, GHR=0, pred_valid=0, pred_taken=0, pred_ctr=0 and pred_index=0.
REQ-035 The table array SHALL NOT be reset; it is initialised by the sweep only.
REQ-036 Reset asserted mid-sweep or mid-operation SHALL restart the full sweep after release.

Structure
REQ-037 A shared package bp_pkg SHALL hold the init_state_t enum (INIT, READY) and the default parameter constants.
REQ-038 A combinational sub-module sat_counter (parameter CTR_W; inputs value and taken; output next value) SHALL implement the saturating update.
REQ-039 The table SHALL be a single-write, combinational-read array of 2**INDEX_W x CTR_W.

Verification (defaults)
REQ-040 Release rst_n -> init_busy high for exactly 256 cycles; then lookup_pc=0x00 -> next cycle pred_valid=1, pred_ctr=1, pred_taken=0, pred_index=0x00.
REQ-041 Four updates to index 0x05 with taken=1 -> GHR=0x0F; then lookup_pc=0x0A -> pred_index=0x05, pred_ctr=3, pred_taken=1 (saturated, not 0).
REQ-042 Three updates to index 0x10 with taken=0 -> entry 0x10 reads 0; a fourth update with taken=0 -> entry 0x10 still reads 0.
REQ-043 With GHR=0, lookup_pc=0x20 in the same cycle as upd_index=0x20, upd_taken=1 -> pred_ctr=2 (bypassed), and ghr_out=0x01 the next cycle.
REQ-044 pht_clear in the same cycle as upd_valid and lookup_valid -> pred_valid=0, GHR=0, init_busy high for 256 cycles, and all entries read 1 afterwards.
REQ-045 rst_n pulsed low at sweep cycle 100 -> outputs zero immediately, and the sweep restarts, taking the full 256 cycles.
